// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter that sequences single accesses into the APB
// master bridge front-end and returns read data or a timeout error to the owner.
module apb_req_arbiter #(
    parameter int unsigned AW      = 9,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    output logic [DW-1:0] rdata0,
    output logic          err0,
    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata1,
    output logic          err1,
    output logic          transfer,
    output logic          read_write,
    output logic [AW-1:0] apb_write_paddr,
    output logic [DW-1:0] apb_write_data,
    output logic [AW-1:0] apb_read_paddr,
    input  logic [DW-1:0] apb_read_data_out,
    input  logic          xfer_done
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          transfer_q, transfer_d;
    logic          read_write_q, read_write_d;
    logic [AW-1:0] wpaddr_q, wpaddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] rpaddr_q, rpaddr_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          win;
    logic          sel_rw;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [CW-1:0] cnt_inc;
    logic          finish;
    logic [DW-1:0] rsp_data;

    // Next-state and next-output logic; outputs are registered for the state being entered
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        transfer_d   = 1'b0;
        read_write_d = read_write_q;
        wpaddr_d     = wpaddr_q;
        wdata_d      = wdata_q;
        rpaddr_d     = rpaddr_q;
        gnt_d        = gnt_q;
        done_d       = 2'b00;
        err_d        = err_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        // prio_q names the requester that wins a tie
        win       = (req0 & req1) ? prio_q : req1;
        sel_rw    = win ? rw1 : rw0;
        sel_addr  = win ? addr1 : addr0;
        sel_wdata = win ? wdata1 : wdata0;
        cnt_inc   = cnt_q + CW'(1);
        finish    = xfer_done | (cnt_inc == CW'(TIMEOUT));
        rsp_data  = (xfer_done & read_write_q) ? apb_read_data_out : '0;

        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    state_d      = S_ISSUE;
                    owner_d      = win;
                    cnt_d        = '0;
                    transfer_d   = 1'b1;
                    read_write_d = sel_rw;
                    gnt_d        = win ? 2'b10 : 2'b01;
                    if (sel_rw) begin
                        rpaddr_d = sel_addr;
                        wpaddr_d = '0;
                        wdata_d  = '0;
                    end else begin
                        rpaddr_d = '0;
                        wpaddr_d = sel_addr;
                        wdata_d  = sel_wdata;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // A completion in the timeout cycle still counts as success
                if (finish) begin
                    state_d         = S_RESP;
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = ~xfer_done;
                    if (owner_q) begin
                        rdata1_d = rsp_data;
                    end else begin
                        rdata0_d = rsp_data;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                prio_d  = ~owner_q;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q      <= S_IDLE;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            transfer_q   <= 1'b0;
            read_write_q <= 1'b0;
            wpaddr_q     <= '0;
            wdata_q      <= '0;
            rpaddr_q     <= '0;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            transfer_q   <= transfer_d;
            read_write_q <= read_write_d;
            wpaddr_q     <= wpaddr_d;
            wdata_q      <= wdata_d;
            rpaddr_q     <= rpaddr_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign gnt0            = gnt_q[0];
    assign gnt1            = gnt_q[1];
    assign done0           = done_q[0];
    assign done1           = done_q[1];
    assign err0            = err_q[0];
    assign err1            = err_q[1];
    assign rdata0          = rdata0_q;
    assign rdata1          = rdata1_q;
    assign transfer        = transfer_q;
    assign read_write      = read_write_q;
    assign apb_write_paddr = wpaddr_q;
    assign apb_write_data  = wdata_q;
    assign apb_read_paddr  = rpaddr_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: requester agents and a bridge model drive
// directed transactions, a negedge monitor pops expected transfers/completions.
module tb_apb_req_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 8;
    localparam int unsigned TIMEOUT = 16;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          req0 = 1'b0, rw0 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [DW-1:0] wdata0 = '0;
    logic          req1 = 1'b0, rw1 = 1'b0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] wdata1 = '0;
    logic          gnt0, done0, err0, gnt1, done1, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          transfer, read_write;
    logic [AW-1:0] apb_write_paddr, apb_read_paddr;
    logic [DW-1:0] apb_write_data;
    logic [DW-1:0] apb_read_data_out = 8'hEE;
    logic          xfer_done = 1'b0;

    apb_req_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1), .err1(err1),
        .transfer(transfer), .read_write(read_write),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
        .xfer_done(xfer_done)
    );

    always #5 pclk = ~pclk;

    typedef struct { logic owner; logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata; int gap; } xfer_t;
    typedef struct { logic owner; logic [DW-1:0] rdata; logic err; int lat; } done_t;
    typedef struct { int dly; logic [DW-1:0] data; } bus_t;
    typedef struct { logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;

    xfer_t xq[$];
    done_t dq[$];
    bus_t  bq[$];
    req_t  rq0[$];
    req_t  rq1[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_xfer_cyc = 0;
    int   last_done_cyc = 0;
    int   xfer_count = 0;
    logic prev_transfer = 1'b0;
    logic abort0 = 1'b0;

    // dly: cycles from transfer to xfer_done; 0 means the bridge never answers
    task automatic issue(input logic owner, input logic rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int gap, input int dly,
                         input logic [DW-1:0] rsp, input bit with_done);
        xfer_t x;
        done_t d;
        bus_t  b;
        req_t  r;
        x.owner = owner; x.rw = rw; x.addr = addr; x.wdata = wdata; x.gap = gap;
        xq.push_back(x);
        if (with_done) begin
            d.owner = owner;
            d.err   = (dly == 0);
            d.rdata = (dly == 0 || !rw) ? '0 : rsp;
            d.lat   = (dly == 0) ? int'(TIMEOUT) + 1 : dly + 1;
            dq.push_back(d);
        end
        b.dly = dly; b.data = rsp;
        bq.push_back(b);
        r.rw = rw; r.addr = addr; r.wdata = wdata;
        if (owner) rq1.push_back(r);
        else       rq0.push_back(r);
    endtask

    task automatic sync();
        @(posedge pclk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        logic [49:0] got;
        got = {gnt0, done0, rdata0, err0, gnt1, done1, rdata1, err1, transfer, read_write,
               apb_write_paddr, apb_write_data, apb_read_paddr};
        checks++;
        if (got != '0) begin
            errors++;
            $display("FAIL %s outputs got %h required 0", tag, got);
        end
    endtask

    task automatic wait_quiet(input string tag);
        int n;
        n = 0;
        while ((rq0.size() != 0 || rq1.size() != 0 || req0 || req1 || dq.size() != 0) && n < 500) begin
            @(negedge pclk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s quiesce got timeout required idle", tag);
        end
        repeat (2) @(negedge pclk);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each transfer and done pulse
    always @(negedge pclk) begin
        xfer_t       e;
        done_t       d;
        logic [28:0] gv, ev;
        logic [9:0]  gd, ed;
        cyc++;
        if (presetn) begin
            checks++;
            if ((gnt0 && gnt1) || (done0 && done1) || (transfer && prev_transfer)) begin
                errors++;
                $display("FAIL excl got gnt=%b%b done=%b%b xfer=%b%b required exclusive one-cycle",
                         gnt1, gnt0, done1, done0, prev_transfer, transfer);
            end
            if (transfer) begin
                checks++;
                if (xq.size() == 0) begin
                    errors++;
                    $display("FAIL xfer got unexpected transfer required none");
                end else begin
                    e  = xq.pop_front();
                    ev = {e.rw, e.rw ? AW'(0) : e.addr, e.rw ? DW'(0) : e.wdata,
                          e.rw ? e.addr : AW'(0), e.owner, ~e.owner};
                    gv = {read_write, apb_write_paddr, apb_write_data, apb_read_paddr, gnt1, gnt0};
                    if (gv != ev) begin
                        errors++;
                        $display("FAIL xfer got %h required %h", gv, ev);
                    end
                    if (e.gap >= 0) begin
                        checks++;
                        if (cyc - last_done_cyc != e.gap) begin
                            errors++;
                            $display("FAIL gap got %0d required %0d", cyc - last_done_cyc, e.gap);
                        end
                    end
                end
                last_xfer_cyc = cyc;
                xfer_count++;
            end
            if (done0 || done1) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL done got unexpected done=%b%b required none", done1, done0);
                end else begin
                    d  = dq.pop_front();
                    ed = {d.owner, d.rdata, d.err};
                    gd = {done1, done1 ? rdata1 : rdata0, done1 ? err1 : err0};
                    if (gd != ed) begin
                        errors++;
                        $display("FAIL done got %h required %h", gd, ed);
                    end
                    checks++;
                    if (cyc - last_xfer_cyc != d.lat) begin
                        errors++;
                        $display("FAIL latency got %0d required %0d", cyc - last_xfer_cyc, d.lat);
                    end
                end
                last_done_cyc = cyc;
            end
        end
        prev_transfer = transfer;
    end

    // Bridge model
    initial begin : bridge
        bus_t b;
        forever begin
            @(negedge pclk);
            if (presetn && transfer && bq.size() != 0) begin
                b = bq.pop_front();
                if (b.dly > 0) begin
                    repeat (b.dly) @(negedge pclk);
                    xfer_done = 1'b1;
                    apb_read_data_out = b.data;
                    @(negedge pclk);
                    xfer_done = 1'b0;
                    apb_read_data_out = 8'hEE;
                end
            end
        end
    end

    initial begin : agent0
        req_t r;
        int   bound;
        forever begin
            if (rq0.size() == 0) begin
                req0 = 1'b0;
                @(negedge pclk);
            end else begin
                r = rq0.pop_front();
                req0 = 1'b1; rw0 = r.rw; addr0 = r.addr; wdata0 = r.wdata;
                bound = 0;
                do begin
                    @(negedge pclk);
                    bound++;
                end while (!done0 && !abort0 && bound < 300);
                if (bound >= 300) begin
                    checks++;
                    errors++;
                    $display("FAIL agent0 got no done required done0");
                end
                abort0 = 1'b0;
            end
        end
    end

    initial begin : agent1
        req_t r;
        int   bound;
        forever begin
            if (rq1.size() == 0) begin
                req1 = 1'b0;
                @(negedge pclk);
            end else begin
                r = rq1.pop_front();
                req1 = 1'b1; rw1 = r.rw; addr1 = r.addr; wdata1 = r.wdata;
                bound = 0;
                do begin
                    @(negedge pclk);
                    bound++;
                end while (!done1 && bound < 300);
                if (bound >= 300) begin
                    checks++;
                    errors++;
                    $display("FAIL agent1 got no done required done1");
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int xc0;
        int n;
        repeat (3) @(negedge pclk);
        check_zero("reset");
        presetn = 1'b1;

        // Single write from requester 0, bridge answers 2 cycles after transfer
        sync();
        issue(1'b0, 1'b0, 9'h005, 8'hA5, -1, 2, 8'h00, 1'b1);
        wait_quiet("write");

        // Single read from requester 1 to the upper slave
        sync();
        issue(1'b1, 1'b1, 9'h10C, 8'h77, -1, 3, 8'h3C, 1'b1);
        wait_quiet("read");

        // Contention over four transactions: strict alternation starting at 0
        sync();
        xc0 = xfer_count;
        issue(1'b0, 1'b0, 9'h021, 8'h11, -1, 1, 8'h00, 1'b1);
        issue(1'b1, 1'b1, 9'h122, 8'h00, 2, 2, 8'h22, 1'b1);
        issue(1'b0, 1'b1, 9'h023, 8'h00, 2, 1, 8'h33, 1'b1);
        issue(1'b1, 1'b0, 9'h124, 8'h44, 2, 4, 8'h00, 1'b1);
        wait_quiet("contend");
        checks++;
        if (xfer_count - xc0 != 4) begin
            errors++;
            $display("FAIL xfer_count got %0d required 4", xfer_count - xc0);
        end

        // Timeout on a read while requester 1 becomes pending
        sync();
        issue(1'b0, 1'b1, 9'h030, 8'h00, -1, 0, 8'h00, 1'b1);
        repeat (5) @(posedge pclk);
        #1;
        issue(1'b1, 1'b0, 9'h131, 8'h5E, 2, 1, 8'h00, 1'b1);
        wait_quiet("timeout");

        // Completion lands in the same cycle as the timeout
        sync();
        issue(1'b0, 1'b1, 9'h040, 8'h00, -1, int'(TIMEOUT), 8'h5A, 1'b1);
        wait_quiet("edge");

        // Reset during WAIT abandons the transaction
        sync();
        issue(1'b0, 1'b0, 9'h050, 8'h99, -1, 0, 8'h00, 1'b0);
        n = 0;
        while (xq.size() != 0 && n < 100) begin
            @(negedge pclk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL midreset got no transfer required transfer");
        end
        repeat (3) @(negedge pclk);
        presetn = 1'b0;
        abort0 = 1'b1;
        @(negedge pclk);
        check_zero("midreset");
        presetn = 1'b1;
        repeat (4) @(negedge pclk);

        // Priority pointer restored: requester 0 wins first contention after reset
        sync();
        issue(1'b0, 1'b0, 9'h061, 8'hC3, -1, 1, 8'h00, 1'b1);
        issue(1'b1, 1'b1, 9'h162, 8'h00, 2, 2, 8'hD4, 1'b1);
        wait_quiet("post_reset");

        checks++;
        if (xq.size() != 0 || dq.size() != 0 || bq.size() != 0) begin
            errors++;
            $display("FAIL leftover got xq=%0d dq=%0d bq=%0d required 0", xq.size(), dq.size(), bq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
